// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: command codes, FSM encoding and framing constants for the memory loader
package mem_loader_pkg;
  localparam logic [7:0] CMD_INSTR = 8'h01;
  localparam logic [7:0] CMD_DATA  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h04;
  localparam int WORD_BYTES = 4;
  localparam int LEN_WIDTH  = 16;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE} state_t;
endpackage

// File: rtl/mem_loader_asm.sv
// mem_loader_asm: little-endian byte-to-word assembler with a done pulse on the last byte
module mem_loader_asm
  import mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        done
);
  logic [1:0]  idx;
  logic [31:0] sr;
  assign word = sr;
  assign done = en && idx == 2'(WORD_BYTES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      sr  <= '0;
    end else if (en) begin
      idx <= idx + 2'd1;
      sr  <= {data, sr[31:8]};
    end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: byte-stream command parser that loads words into instruction/data memory and controls core reset
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = 16,
  parameter int DATA_ADDR_WIDTH  = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_valid_i,
  input  logic [7:0]                  rx_data_i,
  output logic                        rx_ready_o,
  output logic                        instr_req_o,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_o,
  output logic                        instr_we_o,
  output logic [3:0]                  instr_be_o,
  output logic [31:0]                 instr_wdata_o,
  input  logic                        instr_gnt_i,
  output logic                        data_req_o,
  output logic [DATA_ADDR_WIDTH-1:0]  data_addr_o,
  output logic                        data_we_o,
  output logic [3:0]                  data_be_o,
  output logic [31:0]                 data_wdata_o,
  input  logic                        data_gnt_i,
  output logic                        core_rst_n_o,
  output logic                        busy_o,
  output logic                        err_o
);
  localparam int AW = INSTR_ADDR_WIDTH > DATA_ADDR_WIDTH ? INSTR_ADDR_WIDTH : DATA_ADDR_WIDTH;
  state_t               state, state_d;
  logic                 sel, len_hi, core, err, fire, done, gnt, bad;
  logic [AW-1:2]        addr;
  logic [LEN_WIDTH-1:0] cnt, len_next;
  logic [31:0]          word;
  assign rx_ready_o   = rst_n && state != S_WRITE;
  assign fire         = rx_valid_i && rx_ready_o;
  assign busy_o       = state != S_IDLE;
  assign core_rst_n_o = core;
  assign err_o        = err;
  assign len_next     = {rx_data_i, cnt[LEN_WIDTH-1:8]};
  assign gnt          = sel ? data_gnt_i : instr_gnt_i;
  assign bad          = rx_data_i == 8'h00 || rx_data_i > CMD_HALT;
  mem_loader_asm u_asm (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (fire && (state == S_ADDR || state == S_DATA)),
    .data (rx_data_i),
    .word (word),
    .done (done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  state_d = fire && (rx_data_i == CMD_INSTR || rx_data_i == CMD_DATA) ? S_ADDR : S_IDLE;
      S_ADDR:  state_d = done ? S_LEN : S_ADDR;
      S_LEN:   state_d = fire && len_hi ? (len_next == '0 ? S_IDLE : S_DATA) : S_LEN;
      S_DATA:  state_d = done ? S_WRITE : S_DATA;
      S_WRITE: state_d = gnt ? (cnt == LEN_WIDTH'(1) ? S_IDLE : S_DATA) : S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end
  // The address sits in the assembler until DATA bytes start shifting, so it is captured during LEN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel    <= 1'b0;
      len_hi <= 1'b0;
      core   <= 1'b0;
      err    <= 1'b0;
      addr   <= '0;
      cnt    <= '0;
    end else begin
      if (state == S_IDLE && fire) begin
        sel  <= rx_data_i == CMD_DATA;
        core <= rx_data_i == CMD_RUN ? 1'b1 : rx_data_i == CMD_HALT ? 1'b0 : core;
        err  <= err | bad;
      end
      if (state == S_LEN && fire) begin
        cnt    <= len_next;
        len_hi <= !len_hi;
        addr   <= word[AW-1:2];
      end
      if (state == S_WRITE && gnt) begin
        cnt  <= cnt - LEN_WIDTH'(1);
        addr <= addr + 1'b1;
      end
    end
  assign instr_req_o   = state == S_WRITE && !sel;
  assign instr_we_o    = instr_req_o;
  assign instr_be_o    = {4{instr_req_o}};
  assign instr_addr_o  = instr_req_o ? {addr[INSTR_ADDR_WIDTH-1:2], 2'b00} : '0;
  assign instr_wdata_o = instr_req_o ? word : '0;
  assign data_req_o    = state == S_WRITE && sel;
  assign data_we_o     = data_req_o;
  assign data_be_o     = {4{data_req_o}};
  assign data_addr_o   = data_req_o ? {addr[DATA_ADDR_WIDTH-1:2], 2'b00} : '0;
  assign data_wdata_o  = data_req_o ? word : '0;
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized frame stimulus checked against an expected-write list built from the frame rules
module tb_mem_loader;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rx_valid = 1'b0, rx_ready;
  logic [7:0]  rx_data = 8'h00;
  logic        instr_req, instr_we, instr_gnt = 1'b0;
  logic [15:0] instr_addr;
  logic [3:0]  instr_be;
  logic [31:0] instr_wdata;
  logic        data_req, data_we, data_gnt = 1'b0;
  logic [14:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        core_rst_n, busy, err;

  mem_loader dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
    .instr_req_o(instr_req), .instr_addr_o(instr_addr), .instr_we_o(instr_we),
    .instr_be_o(instr_be), .instr_wdata_o(instr_wdata), .instr_gnt_i(instr_gnt),
    .data_req_o(data_req), .data_addr_o(data_addr), .data_we_o(data_we),
    .data_be_o(data_be), .data_wdata_o(data_wdata), .data_gnt_i(data_gnt),
    .core_rst_n_o(core_rst_n), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic p; logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t         obs_q[$], exp_q[$];
  logic [31:0] words[$];
  int          checks = 0, errors = 0, gnt_delay = 0, req_cycles = 0, cyc = 0;
  logic        exp_core = 1'b0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin : mon
    logic p, g;
    logic [31:0] a, d;
    logic [31:0] pa, pd;
    if (!rst_n) begin
      instr_gnt = 1'b0;
      data_gnt  = 1'b0;
      cyc       = 0;
    end else if (instr_req || data_req) begin
      p = data_req;
      a = p ? 32'(data_addr) : 32'(instr_addr);
      d = p ? data_wdata : instr_wdata;
      chk("one_req", 64'({instr_req, data_req}), 64'({!p, p}));
      chk("we_be", 64'(p ? {data_we, data_be} : {instr_we, instr_be}), 64'h1F);
      chk("other_idle", p ? 64'({instr_we, instr_be, instr_addr, instr_wdata})
                          : 64'({data_we, data_be, data_addr, data_wdata}), 64'h0);
      chk("ready_low", 64'(rx_ready), 64'h0);
      if (cyc > 0) chk("stable", {a, d}, {pa, pd});
      pa = a;
      pd = d;
      req_cycles++;
      g = cyc >= gnt_delay;
      if (g) obs_q.push_back({p, a, d});
      cyc = g ? 0 : cyc + 1;
      instr_gnt = p ? 1'($urandom_range(0, 1)) : g;
      data_gnt  = p ? g : 1'($urandom_range(0, 1));
    end else begin
      chk("instr_idle", 64'({instr_we, instr_be, instr_addr, instr_wdata}), 64'h0);
      chk("data_idle", 64'({data_we, data_be, data_addr, data_wdata}), 64'h0);
      instr_gnt = 1'($urandom_range(0, 1));
      data_gnt  = 1'($urandom_range(0, 1));
      cyc = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(rx_ready), 64'h1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle", 64'(busy), 64'h0);
  endtask

  task automatic load(input logic port, input logic [31:0] base, input int delay);
    logic [31:0] mask, a;
    logic [15:0] len;
    mask = port ? 32'h7FFF : 32'hFFFF;
    len  = 16'(words.size());
    gnt_delay = delay;
    obs_q.delete();
    exp_q.delete();
    req_cycles = 0;
    foreach (words[i]) begin
      a = ((base & 32'hFFFF_FFFC) + 32'(4 * i)) & mask;
      exp_q.push_back({port, a, words[i]});
    end
    send(port ? 8'h02 : 8'h01);
    for (int i = 0; i < 4; i++) send(base[8*i +: 8]);
    send(len[7:0]);
    send(len[15:8]);
    foreach (words[i]) for (int j = 0; j < 4; j++) send(words[i][8*j +: 8]);
    wait_idle();
    chk("n_writes", 64'(obs_q.size()), 64'(exp_q.size()));
    chk("req_cycles", 64'(req_cycles), 64'(words.size() * (delay + 1)));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk("wr_port", 64'(obs_q[i].p), 64'(exp_q[i].p));
      chk("wr_addr_data", {obs_q[i].a, obs_q[i].d}, {exp_q[i].a, exp_q[i].d});
    end
    chk("core_kept", 64'(core_rst_n), 64'(exp_core));
  endtask

  initial begin
    #12;
    chk("rst_ready", 64'(rx_ready), 64'h0);
    chk("rst_outs", 64'({instr_req, data_req, core_rst_n, busy, err}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 64'(rx_ready), 64'h1);
    @(negedge clk);

    words = '{32'h0000_0013, 32'hDEAD_BEEF};
    load(1'b0, 32'h0000_0100, 0);

    words = '{32'($urandom), 32'($urandom)};
    load(1'b1, 32'h0000_7FFC, 3);

    words.delete();
    load(1'b0, 32'h0000_0103, 0);

    send(8'h03);
    exp_core = 1'b1;
    chk("run", 64'(core_rst_n), 64'h1);
    send(8'h04);
    exp_core = 1'b0;
    chk("halt", 64'(core_rst_n), 64'h0);
    send(8'h55);
    chk("bad_cmd", 64'({err, busy}), 64'h2);
    words = '{32'($urandom)};
    load(1'b1, 32'($urandom), 1);
    chk("err_sticky", 64'(err), 64'h1);

    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        exp_core = 1'($urandom_range(0, 1));
        send(exp_core ? 8'h03 : 8'h04);
      end
      words.delete();
      repeat ($urandom_range(1, 4)) words.push_back($urandom);
      load(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
    end

    words = '{32'h1122_3344};
    send(8'h01);
    for (int i = 0; i < 4; i++) send(8'h00);
    send(8'h01);
    send(8'h00);
    send(8'h44);
    send(8'h33);
    rx_valid = 1'b1;
    rx_data  = 8'h22;
    #2 rst_n = 1'b0;
    #1;
    exp_core = 1'b0;
    chk("async_rst_ready", 64'(rx_ready), 64'h0);
    chk("async_rst_outs", 64'({instr_req, data_req, core_rst_n, busy, err}), 64'h0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    words = '{32'($urandom), 32'($urandom)};
    load(1'b0, 32'h0000_0200, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
